// File: rtl/prng_xoshiro128p_jump.sv
// xoshiro128+ jump sequencer: sits between the system controller and the PRNG.
// It steps the PRNG 128 times while XOR-accumulating the states selected by the
// jump polynomial, then reseeds the PRNG with the accumulated state.
// Idle: clock-gate and seed interface pass straight through.
module prng_xoshiro128p_jump #(
   parameter logic [31:0] JUMP_0      = 32'h8764000b,
   parameter logic [31:0] JUMP_1      = 32'hf542d2d3,
   parameter logic [31:0] JUMP_2      = 32'h6fa035c3,
   parameter logic [31:0] JUMP_3      = 32'h77f2db5b,
   parameter logic [31:0] LONG_JUMP_0 = 32'hb523952e,
   parameter logic [31:0] LONG_JUMP_1 = 32'h0b6f099f,
   parameter logic [31:0] LONG_JUMP_2 = 32'hccf5a0ef,
   parameter logic [31:0] LONG_JUMP_3 = 32'h1c580662
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_cg,
   input  logic        i_seedValid,
   input  logic [31:0] i_seedS0,
   input  logic [31:0] i_seedS1,
   input  logic [31:0] i_seedS2,
   input  logic [31:0] i_seedS3,
   input  logic        i_req,
   input  logic        i_long,
   input  logic [31:0] i_s0,
   input  logic [31:0] i_s1,
   input  logic [31:0] i_s2,
   input  logic [31:0] i_s3,
   output logic        o_cg,
   output logic        o_seedValid,
   output logic [31:0] o_seedS0,
   output logic [31:0] o_seedS1,
   output logic [31:0] o_seedS2,
   output logic [31:0] o_seedS3,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned W      = 32;
   localparam int unsigned CW     = 7;
   localparam int unsigned NSTEPS = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOAD = 2'd2
   } state_t;

   // Polynomial constants flattened so step k selects bit k directly
   // (bit k mod 32 of word k div 32).
   localparam logic [NSTEPS-1:0] JUMP_C      = {JUMP_3, JUMP_2, JUMP_1, JUMP_0};
   localparam logic [NSTEPS-1:0] LONG_JUMP_C = {LONG_JUMP_3, LONG_JUMP_2, LONG_JUMP_1, LONG_JUMP_0};

   state_t             state_q, state_d;
   logic [CW-1:0]      k_q, k_d;
   logic [3:0][W-1:0]  acc_q, acc_d;
   logic               long_q, long_d;
   logic               busy_d, done_d;
   logic [3:0][W-1:0]  prng_s;
   logic               sel_bit;

   assign prng_s  = {i_s3, i_s2, i_s1, i_s0};
   assign sel_bit = long_q ? LONG_JUMP_C[k_q] : JUMP_C[k_q];

   // State, step counter, accumulator and registered status outputs
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         long_q  <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         long_q  <= long_d;
         o_busy  <= busy_d;
         o_done  <= done_d;
      end
   end

   // Next-state, accumulation and PRNG control outputs
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      acc_d       = acc_q;
      long_d      = long_q;
      o_cg        = 1'b1;
      o_seedValid = 1'b0;
      o_seedS0    = acc_q[0];
      o_seedS1    = acc_q[1];
      o_seedS2    = acc_q[2];
      o_seedS3    = acc_q[3];

      case (state_q)
         IDLE: begin
            o_cg        = i_cg;
            o_seedValid = i_seedValid;
            o_seedS0    = i_seedS0;
            o_seedS1    = i_seedS1;
            o_seedS2    = i_seedS2;
            o_seedS3    = i_seedS3;
            if (i_req) begin
               long_d  = i_long;
               acc_d   = '0;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Accumulate the state seen before this cycle's PRNG step
            if (sel_bit) begin
               acc_d = acc_q ^ prng_s;
            end
            k_d = k_q + CW'(1);
            if (k_q == CW'(NSTEPS - 1)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            o_seedValid = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_q == LOAD);
   end

endmodule

// File: tb/tb_prng_xoshiro128p_jump.sv
// Bench for prng_xoshiro128p_jump: a behavioural xoshiro128+ sits behind the
// sequencer, and every cycle the sequencer outputs are compared against a
// latency model plus the C-style jump()/long_jump() reference.
module tb_prng_xoshiro128p_jump;

   typedef logic [3:0][31:0] st_t;   // [0]=s0 .. [3]=s3

   logic        clk;
   logic        rstn;
   logic        i_cg, i_seedValid, i_req, i_long;
   logic [31:0] i_seedS0, i_seedS1, i_seedS2, i_seedS3;
   logic        o_cg, o_seedValid, o_busy, o_done;
   logic [31:0] o_seedS0, o_seedS1, o_seedS2, o_seedS3;
   st_t         prng;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   prng_xoshiro128p_jump dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_cg(i_cg), .i_seedValid(i_seedValid),
      .i_seedS0(i_seedS0), .i_seedS1(i_seedS1), .i_seedS2(i_seedS2), .i_seedS3(i_seedS3),
      .i_req(i_req), .i_long(i_long),
      .i_s0(prng[0]), .i_s1(prng[1]), .i_s2(prng[2]), .i_s3(prng[3]),
      .o_cg(o_cg), .o_seedValid(o_seedValid),
      .o_seedS0(o_seedS0), .o_seedS1(o_seedS1), .o_seedS2(o_seedS2), .o_seedS3(o_seedS3),
      .o_busy(o_busy), .o_done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // xoshiro128+ step, written as in the C reference
   function automatic st_t nxt(input st_t s);
      logic [31:0] t;
      t = s[1] << 9;
      s[2] ^= s[0];
      s[3] ^= s[1];
      s[1] ^= s[2];
      s[0] ^= s[3];
      s[2] ^= t;
      s[3] = (s[3] << 11) | (s[3] >> 21);
      return s;
   endfunction

   // C reference jump()/long_jump()
   function automatic st_t jump_ref(input st_t s_in, input bit lng);
      logic [31:0] cw [4];
      st_t s, acc;
      if (lng) begin
         cw[0] = 32'hb523952e; cw[1] = 32'h0b6f099f; cw[2] = 32'hccf5a0ef; cw[3] = 32'h1c580662;
      end else begin
         cw[0] = 32'h8764000b; cw[1] = 32'hf542d2d3; cw[2] = 32'h6fa035c3; cw[3] = 32'h77f2db5b;
      end
      s   = s_in;
      acc = '0;
      for (int i = 0; i < 4; i++) begin
         for (int b = 0; b < 32; b++) begin
            if (((cw[i] >> b) & 32'd1) != 32'd0) acc ^= s;
            s = nxt(s);
         end
      end
      return acc;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Behavioural PRNG: a seed load wins over the clock-gated step
   initial prng = '0;
   always @(posedge clk) begin
      if (o_seedValid)  prng <= {o_seedS3, o_seedS2, o_seedS1, o_seedS0};
      else if (o_cg)    prng <= nxt(prng);
   end

   // Latency model: m_cnt = cycles since acceptance (0 = idle),
   // RUN occupies 1..128, LOAD is 129, done follows in the next cycle.
   int  m_cnt;
   bit  m_done;
   st_t m_exp;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= (m_cnt == 129);
         if (m_cnt == 0) begin
            if (i_req) begin
               m_cnt <= 1;
               m_exp <= jump_ref(i_seedValid ? {i_seedS3, i_seedS2, i_seedS1, i_seedS0} : prng, i_long);
            end
         end else if (m_cnt == 129) begin
            m_cnt <= 0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      chk("busy", 128'(o_busy), 128'(m_cnt != 0));
      chk("done", 128'(o_done), 128'(m_done));
      if (m_cnt == 0) begin
         chk("idle_cg", 128'(o_cg), 128'(i_cg));
         chk("idle_sv", 128'(o_seedValid), 128'(i_seedValid));
         chk("idle_seed", {o_seedS3, o_seedS2, o_seedS1, o_seedS0},
             {i_seedS3, i_seedS2, i_seedS1, i_seedS0});
      end else begin
         chk("busy_cg", 128'(o_cg), 128'd1);
         chk("busy_sv", 128'(o_seedValid), 128'(m_cnt == 129));
         if (m_cnt == 129)
            chk("load_seed", {o_seedS3, o_seedS2, o_seedS1, o_seedS0}, m_exp);
      end
      if (m_done) chk("done_state", prng, m_exp);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_seed(input st_t s);
      i_seedS0 = s[0]; i_seedS1 = s[1]; i_seedS2 = s[2]; i_seedS3 = s[3];
   endtask

   function automatic st_t rnd_state();
      st_t s;
      for (int i = 0; i < 4; i++) s[i] = $urandom;
      return s;
   endfunction

   // One jump with noisy external inputs during RUN; optional reset at run cycle rst_at
   task automatic do_jump(input st_t seed, input bit lng, input bit same_cycle, input int rst_at);
      int  nb;
      bit  seen;
      nb   = 0;
      seen = 1'b0;
      if (!same_cycle) begin
         i_seedValid = 1'b1; set_seed(seed);
         tick();
         i_seedValid = 1'b0;
      end
      i_req = 1'b1; i_long = lng;
      if (same_cycle) begin
         i_seedValid = 1'b1; set_seed(seed);
      end
      tick();
      for (int c = 0; c < 300; c++) begin
         i_cg        = 1'($urandom);
         i_seedValid = (c == 40) ? 1'b1 : 1'($urandom);
         i_req       = (c == 40) ? 1'b1 : 1'b0;
         i_long      = 1'($urandom);
         set_seed(rnd_state());
         if (c == rst_at) begin
            i_cg = 1'b0; i_seedValid = 1'b0;
            rstn = 1'b0;
            @(negedge clk);
            chk("rst_busy", 128'(o_busy), 128'd0);
            chk("rst_done", 128'(o_done), 128'd0);
            chk("rst_cg", 128'(o_cg), 128'(i_cg));
            tick();
            rstn = 1'b1;
            i_req = 1'b0;
            return;
         end
         @(negedge clk);
         if (o_done) begin
            seen = 1'b1;
            break;
         end
         if (o_busy) nb++;
         @(posedge clk);
         #1;
      end
      chk("done_seen", 128'(seen), 128'd1);
      chk("busy_len", 128'(nb), 128'd129);
      chk("jump_state", prng, jump_ref(seed, lng));
      tick();
      i_req = 1'b0; i_seedValid = 1'b0; i_cg = 1'b0;
   endtask

   // Wait for o_done at a negedge, bounded
   task automatic wait_done(output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (o_done) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      int  t1, t2;
      bit  ok1, ok2;
      st_t s;

      rstn = 1'b0; i_cg = 1'b0; i_seedValid = 1'b0; i_req = 1'b0; i_long = 1'b0;
      set_seed('0);

      // Pin the step function against hand-computed values
      chk("lit_next1", nxt({32'd4, 32'd3, 32'd2, 32'd1}), {32'd12288, 32'd1026, 32'd0, 32'd7});
      chk("lit_zero_jump", jump_ref('0, 1'b0), 128'd0);

      @(negedge clk);
      chk("reset_busy", 128'(o_busy), 128'd0);
      chk("reset_done", 128'(o_done), 128'd0);
      tick(); tick();
      rstn = 1'b1;
      tick();
      chk("post_reset_busy", 128'(o_busy), 128'd0);

      // Idle pass-through
      i_seedValid = 1'b1; i_cg = 1'b0;
      set_seed({32'd4, 32'd3, 32'd2, 32'd1});
      @(negedge clk);
      chk("pt_sv", 128'(o_seedValid), 128'd1);
      chk("pt_cg", 128'(o_cg), 128'd0);
      chk("pt_seed", {o_seedS3, o_seedS2, o_seedS1, o_seedS0}, {32'd4, 32'd3, 32'd2, 32'd1});
      tick();
      chk("pt_loaded", prng, {32'd4, 32'd3, 32'd2, 32'd1});
      i_seedValid = 1'b0; i_cg = 1'b1;
      tick();
      chk("pt_step", prng, {32'd12288, 32'd1026, 32'd0, 32'd7});
      i_cg = 1'b0;

      // Directed jumps
      do_jump({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, -1);
      do_jump({32'hcafef00d, 32'h89abcdef, 32'h01234567, 32'hdeadbeef}, 1'b1, 1'b0, -1);
      do_jump('0, 1'b0, 1'b1, -1);
      chk("zero_state", prng, 128'd0);
      do_jump(rnd_state(), 1'b0, 1'b1, -1);

      // Back-to-back long jumps with i_req held
      s = {32'hcafef00d, 32'h89abcdef, 32'h01234567, 32'hdeadbeef};
      i_seedValid = 1'b1; set_seed(s);
      tick();
      i_seedValid = 1'b0; i_req = 1'b1; i_long = 1'b1;
      tick();
      wait_done(t1, ok1);
      chk("b2b_first_state", prng, jump_ref(s, 1'b1));
      tick();
      i_req = 1'b0;
      wait_done(t2, ok2);
      chk("b2b_seen", {ok1, ok2}, 128'd3);
      chk("b2b_gap", 128'(t2 - t1), 128'd130);
      chk("b2b_state", prng, jump_ref(jump_ref(s, 1'b1), 1'b1));
      tick();

      // Reset mid-RUN, then a fresh jump
      do_jump(rnd_state(), 1'b0, 1'b0, 50);
      tick();
      do_jump({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b1, 1'b0, -1);

      // Randomized jumps
      for (int r = 0; r < 6; r++) begin
         do_jump(rnd_state(), 1'($urandom), 1'($urandom), -1);
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
